// File: rtl/regfile_write_sequencer.sv
// Register-file write-port owner: arbitrates mem/ALU writebacks and serializes
// each 16-bit writeback into masked nibble writes, one quarter per cycle.
module regfile_write_sequencer #(
    parameter int ROUND_ROBIN = 0,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [2:0]        mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [3:0]        mem_mask,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [2:0]        alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic [3:0]        alu_mask,
    output logic              rf_write,
    output logic [4:0]        rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [1:0]        rf_quarter,
    output logic              done,
    output logic              pend_valid,
    output logic [2:0]        pend_reg
);
    localparam int NIB_W = 4;

    typedef struct packed {
        logic [2:0]        dst;
        logic [DATA_W-1:0] data;
        logic [3:0]        mask;
    } wb_req_t;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t     state, state_nxt;
    wb_req_t    mem_req, alu_req, src, cap;
    logic       last_alu;
    logic       grant_mem, grant_alu, accept, issue;
    logic [3:0] rem_mask, cur_mask, clr_mask;
    logic [1:0] wr_q;
    logic       wr_any;
    logic [NIB_W-1:0] wr_nib;

    assign mem_req = '{dst: mem_reg, data: mem_data, mask: mem_mask};
    assign alu_req = '{dst: alu_reg, data: alu_data, mask: alu_mask};

    // last_alu resets high so the first contended grant goes to mem
    always_comb begin
        grant_mem = 1'b0;
        grant_alu = 1'b0;
        if (mem_valid && alu_valid) begin
            if (ROUND_ROBIN != 0 && !last_alu) grant_alu = 1'b1;
            else                               grant_mem = 1'b1;
        end else if (mem_valid) begin
            grant_mem = 1'b1;
        end else if (alu_valid) begin
            grant_alu = 1'b1;
        end
    end

    assign mem_ready = (state == IDLE) && grant_mem;
    assign alu_ready = (state == IDLE) && grant_alu;
    assign accept    = mem_ready || alu_ready;
    assign issue     = accept || (state == WRITE && rem_mask != 4'b0);

    // In IDLE the first nibble comes straight from the granted payload so the
    // first write lands in the cycle right after the handshake.
    always_comb begin
        src      = cap;
        cur_mask = rem_mask;
        if (state == IDLE) begin
            src      = grant_alu ? alu_req : mem_req;
            cur_mask = src.mask;
        end
    end

    always_comb begin
        wr_any   = |cur_mask;
        wr_q     = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (cur_mask[i]) wr_q = 2'(i);
        clr_mask = cur_mask;
        if (wr_any) clr_mask[wr_q] = 1'b0;
        wr_nib   = src.data[{wr_q, 2'b00} +: NIB_W];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = WRITE;
            WRITE:   if (rem_mask == 4'b0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap           <= '0;
            rem_mask      <= 4'b0;
            last_alu      <= 1'b1;
            rf_write      <= 1'b0;
            rf_write_reg  <= 5'd0;
            rf_write_data <= '0;
            rf_quarter    <= 2'd0;
            done          <= 1'b0;
            pend_valid    <= 1'b0;
            pend_reg      <= 3'd0;
        end else begin
            if (accept) begin
                cap      <= src;
                last_alu <= grant_alu;
            end
            if (issue) begin
                rem_mask   <= clr_mask;
                rf_write   <= wr_any;
                done       <= (clr_mask == 4'b0);
                pend_valid <= 1'b1;
                pend_reg   <= src.dst;
                if (wr_any) begin
                    rf_quarter    <= wr_q;
                    rf_write_data <= {{(DATA_W-NIB_W){1'b0}}, wr_nib};
                    rf_write_reg  <= {2'b00, src.dst};
                end
            end else begin
                rf_write   <= 1'b0;
                done       <= 1'b0;
                pend_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Directed bench: one fixed-priority and one round-robin instance share stimulus.
module tb_regfile_write_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid, alu_valid;
    logic [2:0]  mem_reg, alu_reg;
    logic [15:0] mem_data, alu_data;
    logic [3:0]  mem_mask, alu_mask;

    logic        mem_ready, alu_ready, rf_write, done, pend_valid;
    logic [4:0]  rf_write_reg;
    logic [15:0] rf_write_data;
    logic [1:0]  rf_quarter;
    logic [2:0]  pend_reg;

    logic        mem_ready_rr, alu_ready_rr, rf_write_rr, done_rr, pend_valid_rr;
    logic [4:0]  rf_write_reg_rr;
    logic [15:0] rf_write_data_rr;
    logic [1:0]  rf_quarter_rr;
    logic [2:0]  pend_reg_rr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_write_sequencer #(.ROUND_ROBIN(0), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg),
        .mem_data(mem_data), .mem_mask(mem_mask),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg),
        .alu_data(alu_data), .alu_mask(alu_mask),
        .rf_write(rf_write), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .rf_quarter(rf_quarter), .done(done), .pend_valid(pend_valid), .pend_reg(pend_reg)
    );

    regfile_write_sequencer #(.ROUND_ROBIN(1), .DATA_W(16)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready_rr), .mem_reg(mem_reg),
        .mem_data(mem_data), .mem_mask(mem_mask),
        .alu_valid(alu_valid), .alu_ready(alu_ready_rr), .alu_reg(alu_reg),
        .alu_data(alu_data), .alu_mask(alu_mask),
        .rf_write(rf_write_rr), .rf_write_reg(rf_write_reg_rr), .rf_write_data(rf_write_data_rr),
        .rf_quarter(rf_quarter_rr), .done(done_rr), .pend_valid(pend_valid_rr), .pend_reg(pend_reg_rr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        mem_valid = 1'b0; alu_valid = 1'b0;
        mem_reg = 3'd0; mem_data = 16'h0; mem_mask = 4'h0;
        alu_reg = 3'd0; alu_data = 16'h0; alu_mask = 4'h0;
    endtask

    logic [3:0] beef_nib [4];

    initial begin
        beef_nib[0] = 4'hF; beef_nib[1] = 4'hE; beef_nib[2] = 4'hE; beef_nib[3] = 4'hB;
        rst_n = 1'b0;
        idle_inputs();
        nxt(); nxt();
        smp();
        chk("rst_write", rf_write, 0);
        chk("rst_done", done, 0);
        chk("rst_pend", pend_valid, 0);
        chk("rst_wreg", rf_write_reg, 0);
        chk("rst_wdata", rf_write_data, 0);
        chk("rst_quarter", rf_quarter, 0);
        chk("rst_pend_reg", pend_reg, 0);

        // full-word mem write
        nxt();
        rst_n = 1'b1;
        mem_valid = 1'b1; mem_reg = 3'd2; mem_data = 16'hBEEF; mem_mask = 4'hF;
        smp();
        chk("t1_mem_ready", mem_ready, 1);
        chk("t1_alu_ready", alu_ready, 0);
        for (int c = 1; c <= 4; c++) begin
            nxt();
            idle_inputs();
            smp();
            chk("t1_write", rf_write, 1);
            chk("t1_quarter", rf_quarter, c - 1);
            chk("t1_data", rf_write_data, {12'h0, beef_nib[c-1]});
            chk("t1_wreg", rf_write_reg, 5'd2);
            chk("t1_pend", pend_valid, 1);
            chk("t1_pend_reg", pend_reg, 3'd2);
            chk("t1_done", done, (c == 4) ? 1 : 0);
        end

        // sparse alu mask 1010
        nxt();
        alu_valid = 1'b1; alu_reg = 3'd5; alu_data = 16'h1234; alu_mask = 4'b1010;
        smp();
        chk("t2_idle_write", rf_write, 0);
        chk("t2_idle_pend", pend_valid, 0);
        chk("t2_alu_ready", alu_ready, 1);
        nxt();
        idle_inputs();
        smp();
        chk("t2_w0", rf_write, 1);
        chk("t2_q0", rf_quarter, 1);
        chk("t2_d0", rf_write_data, 16'h0003);
        chk("t2_wreg", rf_write_reg, 5'd5);
        chk("t2_done0", done, 0);
        nxt();
        smp();
        chk("t2_w1", rf_write, 1);
        chk("t2_q1", rf_quarter, 3);
        chk("t2_d1", rf_write_data, 16'h0001);
        chk("t2_done1", done, 1);

        // zero mask on alu
        nxt();
        alu_valid = 1'b1; alu_reg = 3'd4; alu_data = 16'hFFFF; alu_mask = 4'b0000;
        smp();
        chk("t3_prev_end_write", rf_write, 0);
        chk("t3_alu_ready", alu_ready, 1);
        nxt();
        alu_reg = 3'd1; alu_data = 16'h0007; alu_mask = 4'b0001;
        smp();
        chk("t3_zm_done", done, 1);
        chk("t3_zm_write", rf_write, 0);
        chk("t3_zm_pend", pend_valid, 1);
        chk("t3_zm_pend_reg", pend_reg, 3'd4);
        chk("t3_zm_wreg_hold", rf_write_reg, 5'd5);
        chk("t3_zm_not_ready", alu_ready, 0);
        nxt();
        smp();
        chk("t3_reaccept", alu_ready, 1);
        nxt();
        idle_inputs();
        smp();
        chk("t3_w", rf_write, 1);
        chk("t3_q", rf_quarter, 0);
        chk("t3_d", rf_write_data, 16'h0007);
        chk("t3_wreg", rf_write_reg, 5'd1);
        chk("t3_done", done, 1);

        // both valid continuously: fixed priority vs round robin
        nxt();
        mem_valid = 1'b1; mem_reg = 3'd3; mem_data = 16'h5678; mem_mask = 4'hF;
        alu_valid = 1'b1; alu_reg = 3'd6; alu_data = 16'h9ABC; alu_mask = 4'hF;
        for (int r = 0; r < 15; r++) begin
            if (r != 0) nxt();
            smp();
            chk("t4_fp_alu_ready", alu_ready, 0);
            chk("t4_fp_mem_ready", mem_ready, (r % 5 == 0) ? 1 : 0);
            chk("t4_rr_mem_ready", mem_ready_rr, (r == 0 || r == 10) ? 1 : 0);
            chk("t4_rr_alu_ready", alu_ready_rr, (r == 5) ? 1 : 0);
            if (r == 6) begin
                chk("t4_fp_wreg", rf_write_reg, 5'd3);
                chk("t4_rr_wreg", rf_write_reg_rr, 5'd6);
                chk("t4_rr_data", rf_write_data_rr, 16'h000C);
            end
        end

        // reset in the middle of a full-word write
        nxt();
        idle_inputs();
        mem_valid = 1'b1; mem_reg = 3'd7; mem_data = 16'h4321; mem_mask = 4'hF;
        smp();
        chk("t5_mem_ready", mem_ready, 1);
        nxt();
        idle_inputs();
        smp();
        chk("t5_q0", rf_quarter, 0);
        chk("t5_d0", rf_write_data, 16'h0001);
        nxt();
        rst_n = 1'b0;
        smp();
        chk("t5_q1", rf_quarter, 1);
        chk("t5_w1", rf_write, 1);
        nxt();
        rst_n = 1'b1;
        smp();
        chk("t5_abort_write", rf_write, 0);
        chk("t5_abort_pend", pend_valid, 0);
        chk("t5_abort_done", done, 0);
        for (int c = 0; c < 3; c++) begin
            nxt();
            smp();
            chk("t5_no_late_write", rf_write, 0);
            chk("t5_no_late_done", done, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
